imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the pipelined RV32I core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially from address 0 into the instruction memory. The core's fetch stage is the reader of that memory. While loading, the block holds the processor in reset, and it releases the core once the last word is written.

## Interface
- MEM_DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, $clog2(MEM_DEPTH), word address width (derived; not overridden).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  request a load session; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; latched when start is accepted.
- rx_valid  in  1  rx_data carries a byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word to write.
- core_rst  out  1  active-high reset to processor_top.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse when a session completes.
- err  out  1  sticky error: word_count > MEM_DEPTH.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE. All outputs are decoded from state or registers; there are no combinational paths from inputs to outputs.
- IDLE: rx_ready=0, busy=0.
  - start with word_count==0: go to DONE, no writes.
  - start with word_count>MEM_DEPTH: set err, stay in IDLE. core_rst is unchanged.
  - Otherwise: latch word_count, clear err, clear word index and byte index, set core_rst=1, go to RECV.
- RECV: rx_ready=1, busy=1.
  - A byte is accepted on an edge where rx_valid&&rx_ready. It is stored in lane byte_idx: the first byte goes to [7:0], the fourth to [31:24].
  - byte_idx increments 0..3. Acceptance of byte 3 moves to WRITE.
- WRITE: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word, rx_ready=0.
  - If word index == count-1, go to DONE.
  - Otherwise increment the word index and return to RECV.
- DONE: done=1 for one cycle, busy=1, then go to IDLE. core_rst is cleared on the DONE→IDLE edge.
- start outside IDLE is ignored and not queued.
- The word index never exceeds count-1 ≤ MEM_DEPTH-1, so there is no address wrap.
- Reset asserted mid-session: the partial word is discarded, no write is issued, and the state returns to IDLE.

## Timing
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_rst=1. The core stays held until the first successful load.
- start accepted at edge E: rx_ready=1 from the cycle after E.
- Fourth byte of a word accepted at edge N: imem_we=1 in cycle N+1, and rx_ready=1 again from N+2. Maximum rate is one word per 5 cycles.
- Last write in cycle N+1: done=1 in cycle N+2, and core_rst=0 and busy=0 from cycle N+3.
- word_count==0: done one cycle after start is accepted; core_rst=0 the cycle after that.
- imem_addr and imem_wdata are stable during the imem_we cycle. Outside WRITE they hold their last values.
- rx_data is sampled only on handshake edges. The producer holding rx_valid with rx_ready low is legal and stalls nothing.

## Test plan
- Load word_count=2 with bytes 93 02 A0 00 13 83 42 01 → writes mem[0]=0x00A00293 and mem[1]=0x01428313. Expect one done pulse and core_rst=0 afterwards. The core then runs, giving x5=10.
- Same stream with rx_valid toggling randomly and gaps of 0–3 cycles → identical memory contents, exactly 2 imem_we pulses, no duplicated or dropped byte.
- start with word_count=0 → done next cycle, no imem_we, core_rst=0 one cycle later.
- start with word_count=MEM_DEPTH+1 → err=1, no imem_we, no done, state IDLE. A following valid start clears err.
- Assert rst after 2 bytes of word 0 → immediately rx_ready=0, imem_we=0, core_rst=1, and no write ever occurs. A fresh 1-word load afterwards succeeds.
- Full load of word_count=MEM_DEPTH → last write at addr MEM_DEPTH-1, done once. A start pulsed mid-load has no effect.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Program loader for the pipelined RV32I core. Receives a byte stream over a
//   valid/ready handshake. It packs each group of four bytes into a
//   little-endian 32-bit word and writes the words to instruction memory at
//   consecutive addresses, starting from 0. The core is held in reset while a
//   session is running and is released once the last word has been written.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   start       request a load session (looked at only while idle)
//   word_count  number of words to load, latched when start is accepted
//   rx_valid    rx_data carries a byte
//   rx_data     stream byte
//   rx_ready    loader takes a byte on this cycle's edge if rx_valid is high
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_addr   word address, held between writes
//   imem_wdata  word to write, held between writes
//   core_rst    active-high reset to the processor
//   busy        session in progress
//   done        one-cycle pulse when a session completes
//   err         sticky: last start asked for more words than the memory holds
//
// Every output is a register. No path runs combinationally from an input to
// an output, so the producer and the memory see clean timing.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    // word_count is one bit wider than an address, so the depth fits exactly.
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state;
    logic [ADDR_W:0]   count;     // words requested for this session
    logic [ADDR_W-1:0] word_idx;  // address of the word being assembled
    logic [1:0]        byte_idx;  // next byte lane to fill
    logic [2:0][7:0]   lane;      // bytes 0..2 of the current word

    logic accept;
    logic last_word;

    // rx_ready is registered and high only in RECV, so a handshake here is
    // always a RECV-state acceptance.
    assign accept    = rx_valid && rx_ready;
    // count >= 1 whenever this is consulted, so count-1 cannot underflow.
    assign last_word = ({1'b0, word_idx} == (count - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Reset discards any partial word. No write is pending, and the
            // core stays held until a load completes.
            state      <= S_IDLE;
            count      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            lane       <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            // Empty program: complete straight away, no writes.
                            busy  <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (word_count > DEPTH) begin
                            // Refuse the session. The core reset state is left
                            // as it is.
                            err <= 1'b1;
                        end else begin
                            count    <= word_count;
                            err      <= 1'b0;
                            word_idx <= '0;
                            byte_idx <= '0;
                            core_rst <= 1'b1;
                            busy     <= 1'b1;
                            rx_ready <= 1'b1;
                            state    <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    if (accept) begin
                        for (int i = 0; i < 3; i++) begin
                            if (byte_idx == 2'(i))
                                lane[i] <= rx_data;
                        end
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // The fourth byte goes directly into the top lane of
                            // the write data. It is never stored in the lane
                            // buffer.
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {rx_data, lane};
                            rx_ready   <= 1'b0;
                            state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    imem_we <= 1'b0;
                    if (last_word) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        rx_ready <= 1'b1;
                        state    <= S_RECV;
                    end
                end

                S_DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    core_rst <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Inputs are driven on the falling edge and
//   outputs are sampled there. A falling-edge monitor records every memory
//   write and every done pulse, so totals can be checked after each scenario.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] seen [MEM_DEPTH];

    always @(negedge clk) begin
        if (imem_we) begin
            seen[imem_addr] = imem_wdata;
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge. Returns on the falling edge just after the
    // handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) chk("rx_ready_timeout", 32'(t), 0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rand_gap);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], rand_gap ? int'($urandom_range(0, 3)) : 0);
    endtask

    // Pulses start for one cycle. Returns on the falling edge of the cycle
    // that follows the accepting edge.
    task automatic do_start(input logic [ADDR_W:0] n);
        start      = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk(tag, 32'(done), 1);
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    int base_we, base_done, bad;

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_we",       32'(imem_we), 0);
        chk("rst_addr",     32'(imem_addr), 0);
        chk("rst_wdata",    imem_wdata, 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_err",      32'(err), 0);
        chk("rst_core_rst", 32'(core_rst), 1);
        rst = 1'b1;
        @(negedge clk);

        // Zero-word session: done on the next cycle, core released one cycle later.
        do_start('0);
        chk("zero_done",     32'(done), 1);
        chk("zero_core_rst", 32'(core_rst), 1);
        @(negedge clk);
        chk("zero_done_off", 32'(done), 0);
        chk("zero_core_free", 32'(core_rst), 0);
        chk("zero_busy",     32'(busy), 0);
        #1;
        chk("zero_no_we",    32'(we_cnt), 0);
        chk("zero_done_cnt", 32'(done_cnt), 1);

        // Two-word program, back to back, with the timing checked cycle by cycle.
        base_we = we_cnt; base_done = done_cnt;
        do_start(2);
        chk("t1_rx_ready", 32'(rx_ready), 1);
        chk("t1_core_rst", 32'(core_rst), 1);
        chk("t1_busy",     32'(busy), 1);
        send_byte(8'h93, 0); send_byte(8'h02, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
        chk("t1_we0",      32'(imem_we), 1);
        chk("t1_addr0",    32'(imem_addr), 0);
        chk("t1_wdata0",   imem_wdata, 32'h00A0_0293);
        chk("t1_rdy_wr",   32'(rx_ready), 0);
        @(negedge clk);
        chk("t1_rdy_back", 32'(rx_ready), 1);
        chk("t1_we_off",   32'(imem_we), 0);
        send_byte(8'h13, 0); send_byte(8'h83, 0); send_byte(8'h42, 0); send_byte(8'h01, 0);
        chk("t1_we1",      32'(imem_we), 1);
        chk("t1_addr1",    32'(imem_addr), 1);
        chk("t1_wdata1",   imem_wdata, 32'h0142_8313);
        @(negedge clk);
        chk("t1_done",     32'(done), 1);
        chk("t1_held",     32'(core_rst), 1);
        @(negedge clk);
        chk("t1_done_off", 32'(done), 0);
        chk("t1_core_free", 32'(core_rst), 0);
        chk("t1_idle",     32'(busy), 0);
        chk("t1_addr_hold", 32'(imem_addr), 1);
        chk("t1_data_hold", imem_wdata, 32'h0142_8313);
        #1;
        chk("t1_mem0",     seen[0], 32'h00A0_0293);
        chk("t1_mem1",     seen[1], 32'h0142_8313);
        chk("t1_we_cnt",   32'(we_cnt - base_we), 2);
        chk("t1_done_cnt", 32'(done_cnt - base_done), 1);

        // The same program with random gaps between bytes.
        seen[0] = 32'hDEAD_BEEF; seen[1] = 32'hDEAD_BEEF;
        base_we = we_cnt; base_done = done_cnt;
        do_start(2);
        send_word(32'h00A0_0293, 1'b1);
        send_word(32'h0142_8313, 1'b1);
        wait_done("t2_done_timeout");
        @(negedge clk); #1;
        chk("t2_mem0",     seen[0], 32'h00A0_0293);
        chk("t2_mem1",     seen[1], 32'h0142_8313);
        chk("t2_we_cnt",   32'(we_cnt - base_we), 2);
        chk("t2_done_cnt", 32'(done_cnt - base_done), 1);
        chk("t2_core_free", 32'(core_rst), 0);

        // Oversized request sets err. A valid start afterwards clears it.
        base_we = we_cnt; base_done = done_cnt;
        do_start((ADDR_W+1)'(MEM_DEPTH + 1));
        chk("e_err",       32'(err), 1);
        chk("e_busy",      32'(busy), 0);
        chk("e_rx_ready",  32'(rx_ready), 0);
        chk("e_core_rst",  32'(core_rst), 0);
        repeat (5) @(negedge clk);
        #1;
        chk("e_err_sticky", 32'(err), 1);
        chk("e_no_we",     32'(we_cnt - base_we), 0);
        chk("e_no_done",   32'(done_cnt - base_done), 0);
        do_start(1);
        chk("e_err_clr",   32'(err), 0);
        chk("e_rx_ready2", 32'(rx_ready), 1);
        send_word(32'h1234_5678, 1'b0);
        wait_done("e_done_timeout");
        @(negedge clk); #1;
        chk("e_mem0",      seen[0], 32'h1234_5678);

        // Reset in the middle of a word: the partial word is dropped and no
        // write happens.
        base_we = we_cnt;
        do_start(1);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0);
        rx_valid = 1'b1; rx_data = 8'hAD;
        rst = 1'b0;
        #1;
        chk("r_rx_ready",  32'(rx_ready), 0);
        chk("r_we",        32'(imem_we), 0);
        chk("r_core_rst",  32'(core_rst), 1);
        chk("r_busy",      32'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("r_no_we",     32'(we_cnt - base_we), 0);
        chk("r_mem_keep",  seen[0], 32'h1234_5678);
        do_start(1);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_done("r_done_timeout");
        @(negedge clk); #1;
        chk("r_mem0_new",  seen[0], 32'hCAFE_F00D);
        chk("r_we_cnt",    32'(we_cnt - base_we), 1);
        chk("r_core_free", 32'(core_rst), 0);

        // Full-depth load, with a start pulse in the middle that must be ignored.
        base_we = we_cnt; base_done = done_cnt;
        do_start((ADDR_W+1)'(MEM_DEPTH));
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (i == 500) begin start = 1'b1; word_count = 3; end
            send_word(pat(i), 1'b0);
            if (i == 500) start = 1'b0;
        end
        chk("f_we_last",   32'(imem_we), 1);
        chk("f_addr_last", 32'(imem_addr), MEM_DEPTH - 1);
        wait_done("f_done_timeout");
        repeat (6) @(negedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++)
            if (seen[i] !== pat(i)) bad++;
        chk("f_mem_bad",   32'(bad), 0);
        chk("f_we_cnt",    32'(we_cnt - base_we), MEM_DEPTH);
        chk("f_done_cnt",  32'(done_cnt - base_done), 1);
        chk("f_busy",      32'(busy), 0);
        chk("f_core_free", 32'(core_rst), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
